// File: rtl/irq_arbiter.sv
// Interrupt arbiter: captures rising-edge events per channel with data, and
// delivers one unmasked pending event at a time on a valid/ready port.
module irq_arbiter #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 8,
  parameter int MODE   = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_CH-1:0]          interrupt,
  input  logic [N_CH*DATA_W-1:0]   data_i,
  input  logic [N_CH-1:0]          mask_i,
  input  logic                     out_ready_i,
  output logic                     out_valid_o,
  output logic [$clog2(N_CH)-1:0]  out_id_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [N_CH-1:0]          pending_o,
  output logic [N_CH-1:0]          overrun_o
);

  localparam int ID_W = $clog2(N_CH);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t            state;
  logic [N_CH-1:0]   irq_q;
  logic [N_CH-1:0]   pending;
  logic [N_CH-1:0]   overrun;
  logic [ID_W-1:0]   last_id;
  logic [DATA_W-1:0] hold [N_CH];

  logic [N_CH-1:0]   ev;
  logic [N_CH-1:0]   eligible;
  logic [N_CH-1:0]   clr_vec;
  logic              ack;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   idx;

  assign ev        = interrupt & ~irq_q;
  assign eligible  = pending & ~mask_i;
  assign ack       = (state == PRESENT) && out_ready_i;
  assign pending_o = pending;
  assign overrun_o = overrun;

  always_comb begin
    clr_vec = '0;
    if (ack) clr_vec[out_id_o] = 1'b1;
  end

  // Winner search; later loop iterations override earlier ones, so the
  // last assignment is the first channel in search order.
  always_comb begin
    win = '0;
    idx = '0;
    if (MODE == 0) begin
      for (int k = 0; k < N_CH; k++)
        if (eligible[k]) win = ID_W'(k);
    end else begin
      for (int j = N_CH; j >= 1; j--) begin
        idx = ID_W'((int'(last_id) + N_CH - j) % N_CH);
        if (eligible[idx]) win = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < N_CH; k++)
      if (ev[k]) hold[k] <= data_i[k*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      irq_q       <= '0;
      pending     <= '0;
      overrun     <= '0;
      last_id     <= '0;
      out_valid_o <= 1'b0;
      out_id_o    <= '0;
      out_data_o  <= '0;
    end else begin
      irq_q   <= interrupt;
      // A new event on the acked channel keeps it pending but drops overrun.
      pending <= (pending & ~clr_vec) | ev;
      overrun <= (overrun | (ev & pending)) & ~clr_vec;
      case (state)
        IDLE: begin
          if (|eligible) begin
            out_id_o    <= win;
            out_data_o  <= hold[win];
            out_valid_o <= 1'b1;
            state       <= PRESENT;
          end
        end
        PRESENT: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            last_id     <= out_id_o;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: fixed-priority (8 ch) and round-robin (4 ch) instances
// checked every cycle against a rule-level model, plus directed scenarios.
module tb_irq_arbiter;

  logic        clk, rst;
  logic [7:0]  irq0, mask0;
  logic [63:0] dat0;
  logic        rdy0, v0;
  logic [2:0]  id0;
  logic [7:0]  od0, pend0, ovr0;

  logic [3:0]  irq1, mask1;
  logic [31:0] dat1;
  logic        rdy1, v1;
  logic [1:0]  id1;
  logic [7:0]  od1;
  logic [3:0]  pend1, ovr1;

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  irq_arbiter #(.N_CH(8), .DATA_W(8), .MODE(0)) u_fp (
    .clk_i(clk), .rst_i(rst), .interrupt(irq0), .data_i(dat0), .mask_i(mask0),
    .out_ready_i(rdy0), .out_valid_o(v0), .out_id_o(id0), .out_data_o(od0),
    .pending_o(pend0), .overrun_o(ovr0));

  irq_arbiter #(.N_CH(4), .DATA_W(8), .MODE(1)) u_rr (
    .clk_i(clk), .rst_i(rst), .interrupt(irq1), .data_i(dat1), .mask_i(mask1),
    .out_ready_i(rdy1), .out_valid_o(v1), .out_id_o(id1), .out_data_o(od1),
    .pending_o(pend1), .overrun_o(ovr1));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_pend [2];
  logic [7:0] m_ovr  [2];
  logic [7:0] m_prv  [2];
  bit         m_busy [2];
  int         m_id   [2];
  logic [7:0] m_data [2];
  int         m_last [2];
  logic [7:0] m_hold [2][8];

  function automatic int pick(logic [7:0] elig, int n, int mode, int lastid);
    if (mode == 0) begin
      for (int c = n - 1; c >= 0; c--) if (elig[c]) return c;
    end else begin
      for (int j = 1; j <= n; j++) begin
        int c = (lastid - j + n) % n;
        if (elig[c]) return c;
      end
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    int n, aid, w;
    logic [7:0] irq, msk, e, elig;
    logic [63:0] dat;
    logic rdy, ack;
    for (int u = 0; u < 2; u++) begin
      n = (u == 0) ? 8 : 4;
      if (u == 0) begin irq = irq0; msk = mask0; rdy = rdy0; dat = dat0; end
      else begin irq = {4'b0, irq1}; msk = {4'hF, mask1}; rdy = rdy1; dat = {32'b0, dat1}; end
      if (rst) begin
        m_pend[u] = 0; m_ovr[u] = 0; m_prv[u] = 0; m_busy[u] = 0;
        m_id[u] = 0; m_data[u] = 0; m_last[u] = 0;
      end else begin
        ack = m_busy[u] && rdy;
        aid = m_id[u];
        if (!m_busy[u]) begin
          elig = m_pend[u] & ~msk;
          if (elig != 0) begin
            w = pick(elig, n, u, m_last[u]);
            m_busy[u] = 1; m_id[u] = w; m_data[u] = m_hold[u][w];
          end
        end else if (ack) begin
          m_busy[u] = 0; m_last[u] = aid;
          m_pend[u][aid] = 1'b0; m_ovr[u][aid] = 1'b0;
        end
        e = irq & ~m_prv[u];
        for (int k = 0; k < n; k++) begin
          if (e[k]) begin
            if (m_pend[u][k]) m_ovr[u][k] = 1'b1;
            m_pend[u][k] = 1'b1;
            m_hold[u][k] = dat[k*8 +: 8];
          end
        end
        m_prv[u] = irq;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("valid0", 32'(v0), 32'(m_busy[0]));
      cmp("id0", 32'(id0), 32'(m_id[0]));
      cmp("data0", 32'(od0), 32'(m_data[0]));
      cmp("pend0", 32'(pend0), 32'(m_pend[0]));
      cmp("ovr0", 32'(ovr0), 32'(m_ovr[0]));
      cmp("valid1", 32'(v1), 32'(m_busy[1]));
      cmp("id1", 32'(id1), 32'(m_id[1]));
      cmp("data1", 32'(od1), 32'(m_data[1]));
      cmp("pend1", 32'(pend1), 32'(m_pend[1][3:0]));
      cmp("ovr1", 32'(ovr1), 32'(m_ovr[1][3:0]));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_valid(input int u, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = (u == 0) ? v0 : v1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wait_valid%0d: valid not seen within %0d cycles", u, budget);
    end
  endtask

  task automatic pulse0(input logic [7:0] bits);
    irq0 = bits;
    @(negedge clk);
    irq0 = 0;
  endtask

  int         order [8] = '{3, 2, 1, 0, 3, 2, 1, 0};
  logic [7:0] exp_d [4];
  logic [7:0] nd;

  initial begin
    rst = 1; irq0 = 0; mask0 = 0; dat0 = 0; rdy0 = 0;
    irq1 = 0; mask1 = 0; dat1 = 0; rdy1 = 0;
    repeat (3) @(negedge clk);
    chk_on = 1;
    cmp("rst_valid", 32'(v0), 0);
    cmp("rst_id", 32'(id0), 0);
    cmp("rst_data", 32'(od0), 0);
    cmp("rst_pend", 32'(pend0), 0);
    cmp("rst_ovr", 32'(ovr0), 0);
    rst = 0;
    @(negedge clk);

    // Fixed priority: 1,5,6 in one cycle
    rdy0 = 1;
    dat0[1*8 +: 8] = 8'h11; dat0[5*8 +: 8] = 8'h55; dat0[6*8 +: 8] = 8'h66;
    irq0 = 8'b0110_0010;
    @(negedge clk); irq0 = 0;
    cmp("fp_lat", 32'(v0), 0);
    @(negedge clk);
    cmp("fp_v1", 32'(v0), 1); cmp("fp_id1", 32'(id0), 6); cmp("fp_d1", 32'(od0), 32'h66);
    @(negedge clk); cmp("fp_gap1", 32'(v0), 0);
    @(negedge clk);
    cmp("fp_v2", 32'(v0), 1); cmp("fp_id2", 32'(id0), 5); cmp("fp_d2", 32'(od0), 32'h55);
    @(negedge clk); cmp("fp_gap2", 32'(v0), 0);
    @(negedge clk);
    cmp("fp_v3", 32'(v0), 1); cmp("fp_id3", 32'(id0), 1); cmp("fp_d3", 32'(od0), 32'h11);
    @(negedge clk);
    cmp("fp_pend_end", 32'(pend0), 0);

    // Round robin on 4 channels, re-pulsing each in its ack cycle
    rdy1 = 1;
    for (int k = 0; k < 4; k++) begin
      exp_d[k] = 8'hC0 + 8'(k);
      dat1[k*8 +: 8] = exp_d[k];
    end
    irq1 = 4'hF;
    @(negedge clk); irq1 = 0;
    for (int r = 0; r < 8; r++) begin
      wait_valid(1, 10);
      cmp("rr_id", 32'(id1), 32'(order[r]));
      cmp("rr_data", 32'(od1), 32'(exp_d[id1]));
      if (r < 4) begin
        nd = 8'(8'h10 * (r + 1)) + 8'(id1);
        exp_d[id1] = nd;
        dat1[id1*8 +: 8] = nd;
        irq1[id1] = 1'b1;
        @(negedge clk);
        cmp("rr_set_over_clr", 32'(pend1[order[r]]), 1);
        cmp("rr_gap", 32'(v1), 0);
        irq1 = 0;
      end
    end
    @(negedge clk);
    cmp("rr_pend_end", 32'(pend1), 0);
    rdy1 = 0;

    // Mask: 7 masked, only 2 granted until the mask clears
    mask0 = 8'h80;
    dat0[7*8 +: 8] = 8'h77; dat0[2*8 +: 8] = 8'h22;
    pulse0(8'h84);
    wait_valid(0, 10);
    cmp("mask_id", 32'(id0), 2); cmp("mask_d", 32'(od0), 32'h22);
    @(negedge clk);
    cmp("mask_pend", 32'(pend0), 32'h80);
    repeat (3) @(negedge clk);
    cmp("mask_idle", 32'(v0), 0);
    mask0 = 0;
    wait_valid(0, 10);
    cmp("unmask_id", 32'(id0), 7); cmp("unmask_d", 32'(od0), 32'h77);
    @(negedge clk);
    cmp("unmask_pend", 32'(pend0), 0);

    // Backpressure and overrun on channel 3
    rdy0 = 0;
    dat0[3*8 +: 8] = 8'hA0;
    pulse0(8'h08);
    wait_valid(0, 10);
    cmp("bp_id", 32'(id0), 3); cmp("bp_d", 32'(od0), 32'hA0);
    repeat (10) @(negedge clk);
    dat0[3*8 +: 8] = 8'hB0;
    pulse0(8'h08);
    @(negedge clk);
    cmp("bp_hold_d", 32'(od0), 32'hA0);
    cmp("bp_ovr", 32'(ovr0[3]), 1);
    cmp("bp_valid", 32'(v0), 1);
    rdy0 = 1;
    @(negedge clk);
    cmp("bp_ack_v", 32'(v0), 0);
    cmp("bp_ack_ovr", 32'(ovr0[3]), 0);
    repeat (3) @(negedge clk);

    // Reset while presenting with three channels pending; line 4 held high
    rdy0 = 0;
    irq0 = 8'h52;
    @(negedge clk); irq0 = 8'h10;
    wait_valid(0, 10);
    cmp("rp_pend", 32'(pend0), 32'h52);
    rst = 1;
    @(negedge clk);
    rst = 0;
    cmp("rp_v", 32'(v0), 0); cmp("rp_pend0", 32'(pend0), 0); cmp("rp_ovr", 32'(ovr0), 0);
    @(negedge clk);
    cmp("rp_fresh", 32'(pend0), 32'h10);
    rdy0 = 1;
    wait_valid(0, 10);
    cmp("rp_id", 32'(id0), 4);
    irq0 = 0;

    // Random traffic, model checked every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      irq0 = 8'($urandom) & 8'($urandom) & 8'($urandom);
      irq1 = 4'($urandom) & 4'($urandom);
      dat0 = {$urandom, $urandom};
      dat1 = $urandom;
      if ($urandom_range(0, 15) == 0) mask0 = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 15) == 0) mask1 = 4'($urandom) & 4'($urandom);
      rdy0 = ($urandom_range(0, 2) != 0);
      rdy1 = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 299) == 0);
    end
    rst = 0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Parametrised interrupt arbiter that captures rising-edge events on N_CH request lines together with a per-channel data word. It selects one unmasked pending channel at a time, by fixed priority or round-robin, and presents its data on a valid/ready output port. It sits between peripheral interrupt sources and the consumer (CPU or DMA front end), and replaces the four-channel combinational priority router with registered, back-pressured delivery.

## Interface
- N_CH, 8: number of interrupt channels (2..32).
- DATA_W, 8: data word width per channel.
- MODE, 0: 0 = fixed priority (highest index wins); 1 = round-robin.
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- interrupt  input  N_CH  level request lines; an event is a 0->1 transition.
- data_i  input  N_CH*DATA_W  packed channel data; channel k occupies [k*DATA_W +: DATA_W].
- mask_i  input  N_CH  1 = channel k is excluded from arbitration; it still latches events.
- out_ready_i  input  1  consumer accepts the presented event.
- out_valid_o  output  1  an event is presented.
- out_id_o  output  $clog2(N_CH)  channel index of the presented event.
- out_data_o  output  DATA_W  data captured with the presented event.
- pending_o  output  N_CH  per-channel pending flags.
- overrun_o  output  N_CH  sticky flags: an event arrived while the channel was already pending.

## Operation
- Edge detect: register interrupt into irq_q. Channel k sees an event when interrupt[k] & ~irq_q[k].
- On an event, pending[k] is set and data_i slice k is stored in hold[k]. The latest event always overwrites hold[k].
- If pending[k] is already 1 when an event arrives, overrun[k] is set.
- Eligible set = pending & ~mask_i.
- FSM with two states:
  - IDLE: if the eligible set is nonzero, pick a winner, copy id and hold[winner] into the output registers, and go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: out_valid_o = 1. On out_ready_i = 1, clear pending[out_id_o] and overrun[out_id_o], update last_id, and go to IDLE.
- Winner selection:
  - MODE 0: highest eligible index.
  - MODE 1: search descends from (last_id - 1) mod N_CH with wrap-around; the first eligible channel wins. last_id resets to 0, so the first search after reset starts at N_CH-1.
- Output stability: out_id_o and out_data_o hold for the whole PRESENT state. New events on the presented channel update hold[] and pending, but not the outputs.
- Set wins over clear: if an event on channel k arrives in the same cycle its grant is acked, pending[k] stays 1 and hold[k] takes the new data. overrun[k] is cleared in that cycle.
- Mask changes during PRESENT do not withdraw the presented event.
- Reset values: out_valid_o = 0, out_id_o = 0, out_data_o = 0, pending = 0, overrun = 0, irq_q = 0, last_id = 0, state = IDLE.
- Reset mid-PRESENT aborts the event. All pending flags are lost.
- A line held high through reset produces an event in the first cycle after reset, because irq_q resets to 0.

## Timing
- A 0->1 transition sampled at edge n sets pending at n (visible cycle n+1). IDLE grants at edge n+1, so out_valid_o is high from cycle n+2. Minimum event-to-valid latency is 2 cycles.
- Handshake completes at the edge where out_valid_o & out_ready_i. out_valid_o is low for at least one cycle after each transfer.
- Peak throughput is one event per 2 cycles.
- out_ready_i may be high before valid; it has no effect in IDLE.
- No combinational path from any input to any output.

## Test plan
- Fixed priority (MODE 0, N_CH 8): pulse channels 1, 5 and 6 in one cycle with data 0x11, 0x55, 0x66, out_ready_i = 1 -> outputs in order (6,0x66), (5,0x55), (1,0x11). First valid appears 2 cycles after the edge, and transfers are 2 cycles apart.
- Round-robin (MODE 1, N_CH 4): hold channels 0..3 pending and re-pulse each one after its ack -> grant order 3,2,1,0,3,…
- Mask: pend channels 7 and 2 with mask_i = 0x80 -> only channel 2 is granted. Clearing the mask -> channel 7 is granted next, and pending_o returns to 0.
- Backpressure and overrun: grant channel 3 (data 0xA0) with out_ready_i = 0 for 10 cycles, then re-pulse channel 3 with 0xB0 -> out_data_o stays 0xA0 and overrun_o[3] = 1. After the ack, channel 3 is presented again with 0xB0, and overrun_o[3] = 0.
- Set-over-clear: an event on the presented channel in the ack cycle -> pending_o[k] stays 1 and the event is re-presented with the new data.
- Reset mid-PRESENT: assert rst_i for 1 cycle while out_valid_o = 1 and 3 channels are pending -> the next cycle shows out_valid_o = 0, pending_o = 0 and overrun_o = 0. A line held high then yields a fresh event.
